// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // Encodings match the MUL/DIV selectors used by the decoder.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int MDU_ITERS = 32;

  // Every quotient bit of a divide by zero is set.
  localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/mdu_shift_core.sv
// Per-iteration datapath: shift-add multiply / restoring divide plus the iteration counter.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic               op_q;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  // Multiply keeps the multiplier in the low half and shifts the carry in from the top;
  // divide keeps {remainder, dividend/quotient} and shifts left one bit per step.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    acc_next  = acc;
    if (op_q == OP_MUL)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc   <= '0;
      opnd  <= '0;
      op_q  <= OP_MUL;
      count <= '0;
    end else if (load_i) begin
      op_q  <= op_i;
      acc   <= (op_i == OP_MUL) ? {{WIDTH{1'b0}}, src2_i} : {{WIDTH{1'b0}}, src1_i};
      opnd  <= (op_i == OP_MUL) ? src1_i : src2_i;
      count <= CW'(WIDTH - 1);
    end else if (step_i) begin
      acc   <= acc_next;
      count <= count - CW'(1);
    end
  end

  assign acc_o  = acc;
  assign last_o = (count == '0);

endmodule

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning the HI/LO pair; FSM, sign handling and MTHI/MTLO live here.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITERS
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               op_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   in1_i,
  input  logic [WIDTH-1:0]   in2_i,
  input  logic               wr_hi_i,
  input  logic               wr_lo_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [2*WIDTH-1:0] hilo_o
);

  mdu_state_t         state;
  logic               op_q;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               accept;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [2*WIDTH-1:0] acc;
  logic               last;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept = ((state == IDLE) || (state == DONE)) && start_i;

  always_comb begin
    mag1 = (signed_i && in1_i[WIDTH-1]) ? -in1_i : in1_i;
    mag2 = (signed_i && in2_i[WIDTH-1]) ? -in2_i : in2_i;
  end

  mdu_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (accept),
    .step_i (state == RUN),
    .op_i   (op_i),
    .src1_i (mag1),
    .src2_i (mag2),
    .acc_o  (acc),
    .last_o (last)
  );

  // A zero divisor leaves the dividend magnitude as remainder, so only the quotient needs overriding.
  always_comb begin
    product = neg_res ? -acc : acc;
    quot    = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    if (div_zero)
      quot = {WIDTH{DIV0_QUOT_BIT}};
    else if (neg_res)
      quot = -quot;
    if (neg_rem)
      rem = -rem;
    res_hi = (op_q == OP_MUL) ? product[2*WIDTH-1:WIDTH] : rem;
    res_lo = (op_q == OP_MUL) ? product[WIDTH-1:0] : quot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_q     <= OP_MUL;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_o <= 1'b0;
          if (wr_hi_i)
            hi <= wr_data_i;
          if (wr_lo_i)
            lo <= wr_data_i;
          if (start_i) begin
            state    <= RUN;
            busy_o   <= 1'b1;
            op_q     <= op_i;
            neg_res  <= signed_i && (in1_i[WIDTH-1] ^ in2_i[WIDTH-1]);
            neg_rem  <= signed_i && in1_i[WIDTH-1];
            div_zero <= (op_i == OP_DIV) && (in2_i == '0);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last)
            state <= FIX;
        end
        FIX: begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
          hi     <= res_hi;
          lo     <= res_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign hi_o   = hi;
  assign lo_o   = lo;
  assign hilo_o = {hi, lo};

endmodule
